// File: rtl/bcd_pkg.sv
// Shared types and constants for the iterative binary-to-BCD converter.
// Provides the FSM state type, the BCD digit width and the double-dabble adjust threshold.
package bcd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   localparam int         BCD_DIGIT_W = 4;
   localparam logic [3:0] ADJ_THRESH  = 4'd5;

endpackage

// File: rtl/bin2bcd_iter_if.sv
// Handshake bundle between a binary producer and the BCD converter.
// The master drives operands and accepts results; the slave is the converter.
interface bin2bcd_iter_if
   import bcd_pkg::*;
#(
   parameter int BIN_W  = 8,
   parameter int DIGITS = 3
);
   logic                          in_valid;
   logic                          in_ready;
   logic [BIN_W-1:0]              bin_in;
   logic                          out_valid;
   logic                          out_ready;
   logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out;
   logic                          overflow;

   modport master (
      output in_valid, bin_in, out_ready,
      input  in_ready, out_valid, bcd_out, overflow
   );

   modport slave (
      input  in_valid, bin_in, out_ready,
      output in_ready, out_valid, bcd_out, overflow
   );
endinterface

// File: rtl/bcd_digit_adj.sv
// One double-dabble digit correction: add 3 when the digit is 5 or more,
// so the following left shift carries correctly into the next decimal digit.
module bcd_digit_adj
   import bcd_pkg::*;
(
   input  logic [3:0] i_digit,
   output logic [3:0] o_digit
);
   assign o_digit = (i_digit >= ADJ_THRESH) ? i_digit + 4'd3 : i_digit;
endmodule

// File: rtl/bin2bcd_iter.sv
// Iterative double-dabble binary-to-BCD converter: one bit per clock,
// valid/ready handshake on both sides, sticky overflow when the value exceeds DIGITS digits.
module bin2bcd_iter
   import bcd_pkg::*;
#(
   parameter int BIN_W  = 8,
   parameter int DIGITS = 3
)(
   input  logic          clk,
   input  logic          rst,
   bin2bcd_iter_if.slave bus
);
   localparam int BCD_W = BCD_DIGIT_W * DIGITS;
   localparam int CNT_W = $clog2(BIN_W + 1);

   state_t           r_state;
   logic [BCD_W-1:0] r_bcd;
   logic [BIN_W-1:0] r_bin;
   logic [CNT_W-1:0] r_cnt;
   logic             r_ovf;
   logic             r_in_ready;
   logic             r_out_valid;

   logic [BCD_W-1:0] w_adj;
   logic [BCD_W-1:0] w_bcd_next;
   logic [BIN_W-1:0] w_bin_next;
   logic             w_ovf_step;

   genvar gi;
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_adj
         bcd_digit_adj u_adj (
            .i_digit (r_bcd[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .o_digit (w_adj[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
         );
      end
   endgenerate

   // The top digit either loses its MSB on the shift or is already out of decimal range.
   assign w_ovf_step = w_adj[BCD_W-1] | (w_adj[BCD_W-1 -: BCD_DIGIT_W] > 4'd9);
   assign w_bcd_next = {w_adj[BCD_W-2:0], r_bin[BIN_W-1]};
   assign w_bin_next = {r_bin[BIN_W-2:0], 1'b0};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_bcd       <= '0;
         r_bin       <= '0;
         r_ovf       <= 1'b0;
         r_cnt       <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.in_valid && r_in_ready) begin
                  r_bin      <= bus.bin_in;
                  r_bcd      <= '0;
                  r_ovf      <= 1'b0;
                  r_cnt      <= CNT_W'(BIN_W);
                  r_in_ready <= 1'b0;
                  r_state    <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               r_bcd <= w_bcd_next;
               r_bin <= w_bin_next;
               r_ovf <= r_ovf | w_ovf_step;
               r_cnt <= r_cnt - CNT_W'(1);
               if (r_cnt == CNT_W'(1)) begin
                  r_state     <= ST_DONE;
                  r_out_valid <= 1'b1;
               end
            end
            ST_DONE: begin
               if (bus.out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= ST_IDLE;
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = r_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.bcd_out   = r_bcd;
   assign bus.overflow  = r_ovf;
endmodule

// File: tb/tb_bin2bcd_iter.sv
// Directed bench for bin2bcd_iter: three parameter sets share one clock and reset,
// a vector table covers conversions, hand sequences cover hold and mid-conversion reset.
module tb_bin2bcd_iter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   bin2bcd_iter_if #(.BIN_W(8),  .DIGITS(3)) b0 ();
   bin2bcd_iter_if #(.BIN_W(16), .DIGITS(5)) b1 ();
   bin2bcd_iter_if #(.BIN_W(8),  .DIGITS(2)) b2 ();

   bin2bcd_iter #(.BIN_W(8),  .DIGITS(3)) u0 (.clk(clk), .rst(rst), .bus(b0.slave));
   bin2bcd_iter #(.BIN_W(16), .DIGITS(5)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));
   bin2bcd_iter #(.BIN_W(8),  .DIGITS(2)) u2 (.clk(clk), .rst(rst), .bus(b2.slave));

   typedef struct {
      int          w;
      logic [31:0] din;
      logic [39:0] exp_bcd;
      logic        exp_ovf;
      int          exp_lat;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [39:0] get_bcd(input int w);
      case (w)
         0:       return {28'h0, b0.bcd_out};
         1:       return {20'h0, b1.bcd_out};
         2:       return {32'h0, b2.bcd_out};
         default: return 40'h0;
      endcase
   endfunction

   function automatic logic get_ov(input int w);
      case (w)
         0:       return b0.out_valid;
         1:       return b1.out_valid;
         2:       return b2.out_valid;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic get_ovf(input int w);
      case (w)
         0:       return b0.overflow;
         1:       return b1.overflow;
         2:       return b2.overflow;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic get_ir(input int w);
      case (w)
         0:       return b0.in_ready;
         1:       return b1.in_ready;
         2:       return b2.in_ready;
         default: return 1'b0;
      endcase
   endfunction

   task automatic drive_in(input int w, input logic v, input logic [31:0] d);
      case (w)
         0: begin b0.in_valid = v; b0.bin_in = d[7:0];  end
         1: begin b1.in_valid = v; b1.bin_in = d[15:0]; end
         2: begin b2.in_valid = v; b2.bin_in = d[7:0];  end
         default: ;
      endcase
   endtask

   task automatic set_ordy(input int w, input logic v);
      case (w)
         0: b0.out_ready = v;
         1: b1.out_ready = v;
         2: b2.out_ready = v;
         default: ;
      endcase
   endtask

   task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Present one operand, then count rising edges (transfer edge = 1) until out_valid.
   task automatic start_wait(input int w, input logic [31:0] d, output int lat);
      @(negedge clk);
      drive_in(w, 1'b1, d);
      @(posedge clk);
      #1 drive_in(w, 1'b0, 32'h0);
      lat = 1;
      while (lat < 100) begin
         @(negedge clk);
         if (get_ov(w)) break;
         @(posedge clk);
         lat++;
      end
   endtask

   task automatic accept(input int w);
      @(negedge clk);
      set_ordy(w, 1'b1);
      @(posedge clk);
      #1 set_ordy(w, 1'b0);
   endtask

   initial begin
      int          lat;
      logic [39:0] got_bcd;
      logic        got_ovf;

      for (int w = 0; w < 3; w++) begin
         drive_in(w, 1'b0, 32'h0);
         set_ordy(w, 1'b0);
      end

      vecs.push_back('{0, 32'h00,   40'h000,   1'b0, 9});
      vecs.push_back('{0, 32'hFF,   40'h255,   1'b0, 9});
      vecs.push_back('{0, 32'h80,   40'h128,   1'b0, 9});
      vecs.push_back('{0, 32'h81,   40'h129,   1'b0, 9});
      vecs.push_back('{0, 32'h7F,   40'h127,   1'b0, 9});
      vecs.push_back('{0, 32'h0A,   40'h010,   1'b0, 9});
      vecs.push_back('{1, 32'hFFFF, 40'h65535, 1'b0, 17});
      vecs.push_back('{1, 32'h2710, 40'h10000, 1'b0, 17});
      vecs.push_back('{1, 32'h0000, 40'h00000, 1'b0, 17});
      vecs.push_back('{2, 32'hFF,   40'h55,    1'b1, 9});
      vecs.push_back('{2, 32'd99,   40'h99,    1'b0, 9});
      vecs.push_back('{2, 32'd100,  40'h00,    1'b1, 9});
      vecs.push_back('{2, 32'h0A,   40'h10,    1'b0, 9});

      // Reset state, observed while rst is held
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int w = 0; w < 3; w++) begin
         chk($sformatf("rst_out_valid%0d", w), {39'h0, get_ov(w)},  40'h0);
         chk($sformatf("rst_overflow%0d", w),  {39'h0, get_ovf(w)}, 40'h0);
         chk($sformatf("rst_bcd%0d", w),       get_bcd(w),          40'h0);
      end
      rst = 1'b0;
      @(negedge clk);
      for (int w = 0; w < 3; w++)
         chk($sformatf("post_rst_in_ready%0d", w), {39'h0, get_ir(w)}, 40'h1);

      // Table-driven conversions
      for (int i = 0; i < vecs.size(); i++) begin
         chk($sformatf("vec%0d_in_ready", i), {39'h0, get_ir(vecs[i].w)}, 40'h1);
         start_wait(vecs[i].w, vecs[i].din, lat);
         got_bcd = get_bcd(vecs[i].w);
         got_ovf = get_ovf(vecs[i].w);
         $display("[TB] vec%0d inst%0d bin=%0h -> bcd=%0h ovf=%0b lat=%0d", i, vecs[i].w,
                  vecs[i].din, got_bcd, got_ovf, lat);
         chk($sformatf("vec%0d_bcd", i), got_bcd, vecs[i].exp_bcd);
         chk($sformatf("vec%0d_ovf", i), {39'h0, got_ovf}, {39'h0, vecs[i].exp_ovf});
         chk($sformatf("vec%0d_lat", i), 40'(lat), 40'(vecs[i].exp_lat));
         accept(vecs[i].w);
         chk($sformatf("vec%0d_ov_drop", i), {39'h0, get_ov(vecs[i].w)}, 40'h0);
         chk($sformatf("vec%0d_ir_rise", i), {39'h0, get_ir(vecs[i].w)}, 40'h1);
      end

      // Result held for 5 cycles with out_ready low; new inputs ignored in DONE
      start_wait(0, 32'h81, lat);
      $display("[TB] hold bin=81 -> bcd=%0h lat=%0d", get_bcd(0), lat);
      chk("hold_lat", 40'(lat), 40'd9);
      drive_in(0, 1'b1, 32'h00);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk($sformatf("hold%0d_ov", k),  {39'h0, get_ov(0)},  40'h1);
         chk($sformatf("hold%0d_bcd", k), get_bcd(0),          40'h129);
         chk($sformatf("hold%0d_ovf", k), {39'h0, get_ovf(0)}, 40'h0);
         chk($sformatf("hold%0d_ir", k),  {39'h0, get_ir(0)},  40'h0);
      end
      drive_in(0, 1'b0, 32'h0);
      accept(0);
      chk("hold_accept_ov", {39'h0, get_ov(0)}, 40'h0);
      chk("hold_accept_ir", {39'h0, get_ir(0)}, 40'h1);

      // Reset pulsed in the fourth SHIFT cycle aborts the conversion
      @(negedge clk);
      drive_in(0, 1'b1, 32'hFF);
      @(posedge clk);
      #1 drive_in(0, 1'b0, 32'h0);
      chk("shift_ir_low", {39'h0, get_ir(0)}, 40'h0);
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("abort_ov",  {39'h0, get_ov(0)},  40'h0);
      chk("abort_bcd", get_bcd(0),          40'h0);
      chk("abort_ovf", {39'h0, get_ovf(0)}, 40'h0);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         chk($sformatf("abort_quiet%0d", k), {39'h0, get_ov(0)}, 40'h0);
      end
      start_wait(0, 32'd200, lat);
      $display("[TB] post-abort bin=200 -> bcd=%0h ovf=%0b lat=%0d", get_bcd(0), get_ovf(0), lat);
      chk("after_abort_bcd", get_bcd(0),          40'h200);
      chk("after_abort_ovf", {39'h0, get_ovf(0)}, 40'h0);
      chk("after_abort_lat", 40'(lat),            40'd9);
      accept(0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/bin2bcd_iter.md
BIN2BCD_ITER -- requirements
Module: bin2bcd_iter

Interface
REQ-001 SHALL have parameter BIN_W, default 8, binary input width (legal range 4..32).
REQ-002 SHALL have parameter DIGITS, default 3, number of BCD output digits (legal range 1..10).
REQ-003 SHALL have port clk  input  1  the only clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  bin_in holds a value to convert.
REQ-006 SHALL have port in_ready  output  1  block can accept a new value.
REQ-007 SHALL have port bin_in  input  BIN_W  unsigned binary operand.
REQ-008 SHALL have port out_valid  output  1  bcd_out and overflow hold a finished result.
REQ-009 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-010 SHALL have port bcd_out  output  4*DIGITS  packed BCD, with digit 0 (units) in bits [3:0].
REQ-011 SHALL have port overflow  output  1  operand did not fit in DIGITS digits.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-013 SHALL assert in_ready only in IDLE; input transfer occurs when in_valid and in_ready are both high on a rising edge.
REQ-014 SHALL, on transfer, capture bin_in into a shift register, clear the BCD accumulator and overflow, load the bit counter with BIN_W, and enter SHIFT.
REQ-015 SHALL, in SHIFT, perform one double-dabble step per cycle:
- add 3 to every digit that is 5 or greater;
- shift {accumulator, operand} left by one;
- decrement the counter.
REQ-016 SHALL set overflow sticky if a 1 is shifted out of the top digit, or if the top digit exceeds 9 after the adjust.
REQ-017 SHALL enter DONE after exactly BIN_W SHIFT cycles and assert out_valid on that edge, giving a fixed latency of BIN_W+1 cycles from input transfer to out_valid.
REQ-018 SHALL hold bcd_out, overflow and out_valid stable in DONE until out_ready is high on a rising edge, then return to IDLE.
REQ-019 SHALL keep in_ready low during SHIFT and DONE; a new input is never accepted in the cycle out_valid drops, because in_ready rises one cycle later (maximum throughput one result per BIN_W+2 cycles).
REQ-020 SHALL, when overflow=1, present bcd_out as the low DIGITS digits of the decimal value (truncation, no saturation).
REQ-021 SHALL ignore in_valid and bin_in changes while not in IDLE, and ignore out_ready while not in DONE.
REQ-022 SHALL drive only legal digits (0..9) on bcd_out whenever out_valid=1 and overflow=0.

Reset
REQ-023 SHALL, on rst high, immediately force state=IDLE, in_ready=1 (after release), out_valid=0, bcd_out=0, overflow=0 and counter=0, independent of clk.
REQ-024 SHALL abort any conversion in progress on reset with no partial result emitted; the first in_valid after rst deasserts is accepted normally.

Structure
REQ-025 SHALL take the FSM state enumeration, the constant BCD_DIGIT_W=4 and the adjust threshold constant 5 from shared package bcd_pkg.
REQ-026 SHALL instantiate DIGITS copies of the combinational sub-module bcd_digit_adj (4-bit in, 4-bit out, +3 when the input is 5 or greater).
REQ-027 SHALL remain synthesizable, with no latches and no combinational path from in_valid to in_ready or from out_ready to out_valid.

Verification
REQ-028 SHALL cover default parameters, bin_in=0x00 -> bcd_out=0x000, overflow=0, out_valid exactly 9 cycles after transfer.
REQ-029 SHALL cover default parameters, inputs 0xFF, 0x80, 0x81, 0x7F -> bcd_out 0x255, 0x128, 0x129, 0x127 respectively, overflow=0.
REQ-030 SHALL cover BIN_W=16, DIGITS=5, bin_in=0xFFFF -> bcd_out=0x65535, overflow=0, latency 17 cycles.
REQ-031 SHALL cover BIN_W=8, DIGITS=2, bin_in=0xFF -> overflow=1, bcd_out=0x55; then bin_in=99 -> bcd_out=0x99, overflow=0.
REQ-032 SHALL cover out_ready held low 5 cycles after out_valid -> bcd_out, overflow and out_valid unchanged, and in_ready=0 throughout; the result is accepted on the cycle out_ready rises.
REQ-033 SHALL cover rst pulsed during cycle 4 of SHIFT -> out_valid stays 0; the next conversion of 200 -> 0x200 with correct latency.
